// File: rtl/hit_damage_ctrl.sv
// -----------------------------------------------------------------------------
// hit_damage_ctrl
//
// Purpose:
//   Round and damage sequencer between the combinational hit detector and the
//   HUD/sprite logic. It samples hit1/hit2 once per video frame and turns each
//   new punch contact into one damage event. It owns both health registers and
//   runs the round FSM (IDLE -> COUNTDOWN -> FIGHT -> KO -> IDLE).
//
// Ports:
//   Clk          in   1   system clock
//   Reset        in   1   asynchronous, active-high reset
//   frame_tick   in   1   one-Clk pulse per frame; every timer counts these
//   start        in   1   start-round key (level), only looked at in IDLE
//   hit1         in   1   player 1 punch landing on player 2 (level)
//   hit2         in   1   player 2 punch landing on player 1 (level)
//   health1      out 10   player 1 health
//   health2      out 10   player 2 health
//   dmg_pulse1   out  1   one-Clk pulse: player 1 took damage on this edge
//   dmg_pulse2   out  1   one-Clk pulse: player 2 took damage on this edge
//   fight_en     out  1   high only in FIGHT
//   round_state  out  2   FSM state: 0=IDLE 1=COUNTDOWN 2=FIGHT 3=KO
//   winner       out  2   0=none 1=P1 2=P2 3=draw, held from KO entry until
//                         the next COUNTDOWN
//
// Configuration macro:
//   HIT_COMBO_EN - when defined, each attacker has a combo window. A hit scored
//                  while the window is still open does double damage.
//
// Timing contract: state changes only on Clk edges where frame_tick=1. On every
// other edge the damage pulses clear and nothing else moves. round_state is the
// FSM state register itself, so it doubles as the state debug view.
// -----------------------------------------------------------------------------
module hit_damage_ctrl #(
   parameter logic [9:0] MAX_HEALTH   = 10'd100,
   parameter logic [9:0] PUNCH_DMG    = 10'd10,
   parameter logic [5:0] HIT_COOLDOWN = 6'd30,
   parameter logic [6:0] START_DELAY  = 7'd60,
   parameter logic [7:0] KO_HOLD      = 8'd120
`ifdef HIT_COMBO_EN
   ,
   parameter logic [5:0] COMBO_WINDOW = 6'd45
`endif
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       hit1,
   input  logic       hit2,
   output logic [9:0] health1,
   output logic [9:0] health2,
   output logic       dmg_pulse1,
   output logic       dmg_pulse2,
   output logic       fight_en,
   output logic [1:0] round_state,
   output logic [1:0] winner
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_COUNTDOWN = 2'd1,
      S_FIGHT     = 2'd2,
      S_KO        = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic [9:0] health1_q, health1_d;
   logic [9:0] health2_q, health2_d;
   logic [5:0] cd1_q, cd1_d;
   logic [5:0] cd2_q, cd2_d;
   logic       hit_prev1_q, hit_prev1_d;
   logic       hit_prev2_q, hit_prev2_d;
   logic       pulse1_q, pulse1_d;
   logic       pulse2_q, pulse2_d;
   logic [1:0] winner_q, winner_d;

   // Damage dealt by each attacker: dmg_to2 comes from hit1, dmg_to1 from hit2.
   logic [9:0] dmg_to1, dmg_to2;

   // A contact scores only on its rising edge across frames, and only when the
   // attacker's cooldown has run out.
   logic score1, score2;
   assign score1 = hit1 & ~hit_prev1_q & (cd1_q == 6'd0);
   assign score2 = hit2 & ~hit_prev2_q & (cd2_q == 6'd0);

`ifdef HIT_COMBO_EN
   logic [5:0] combo1_q, combo1_d;
   logic [5:0] combo2_q, combo2_d;
   assign dmg_to2 = (combo1_q != 6'd0) ? (PUNCH_DMG << 1) : PUNCH_DMG;
   assign dmg_to1 = (combo2_q != 6'd0) ? (PUNCH_DMG << 1) : PUNCH_DMG;
`else
   assign dmg_to2 = PUNCH_DMG;
   assign dmg_to1 = PUNCH_DMG;
`endif

   // Health never wraps: if the damage exceeds what is left, health goes to 0.
   function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [9:0] b);
      return (a < b) ? 10'd0 : (a - b);
   endfunction

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      health1_d   = health1_q;
      health2_d   = health2_q;
      cd1_d       = cd1_q;
      cd2_d       = cd2_q;
      hit_prev1_d = hit_prev1_q;
      hit_prev2_d = hit_prev2_q;
      pulse1_d    = 1'b0;
      pulse2_d    = 1'b0;
      winner_d    = winner_q;
`ifdef HIT_COMBO_EN
      combo1_d    = combo1_q;
      combo2_d    = combo2_q;
`endif

      if (frame_tick) begin
         // Edge history follows the inputs in every state. Because of this, a
         // level held across the COUNTDOWN->FIGHT boundary does not score.
         hit_prev1_d = hit1;
         hit_prev2_d = hit2;
         cd1_d       = (cd1_q != 6'd0) ? cd1_q - 6'd1 : 6'd0;
         cd2_d       = (cd2_q != 6'd0) ? cd2_q - 6'd1 : 6'd0;
`ifdef HIT_COMBO_EN
         combo1_d    = (combo1_q != 6'd0) ? combo1_q - 6'd1 : 6'd0;
         combo2_d    = (combo2_q != 6'd0) ? combo2_q - 6'd1 : 6'd0;
`endif

         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d     = S_COUNTDOWN;
                  health1_d   = MAX_HEALTH;
                  health2_d   = MAX_HEALTH;
                  frame_cnt_d = {1'b0, START_DELAY} - 8'd1;
                  winner_d    = 2'd0;
`ifdef HIT_COMBO_EN
                  combo1_d    = 6'd0;
                  combo2_d    = 6'd0;
`endif
               end
            end

            S_COUNTDOWN: begin
               if (frame_cnt_q == 8'd0) state_d = S_FIGHT;
               else                     frame_cnt_d = frame_cnt_q - 8'd1;
            end

            S_FIGHT: begin
               if (score1) begin
                  cd1_d     = HIT_COOLDOWN - 6'd1;
                  health2_d = sat_sub(health2_q, dmg_to2);
                  pulse2_d  = 1'b1;
`ifdef HIT_COMBO_EN
                  combo1_d  = COMBO_WINDOW - 6'd1;
`endif
               end
               if (score2) begin
                  cd2_d     = HIT_COOLDOWN - 6'd1;
                  health1_d = sat_sub(health1_q, dmg_to1);
                  pulse1_d  = 1'b1;
`ifdef HIT_COMBO_EN
                  combo2_d  = COMBO_WINDOW - 6'd1;
`endif
               end
               // KO is decided on the same edge as the damage that causes it.
               if ((health1_d == 10'd0) || (health2_d == 10'd0)) begin
                  state_d     = S_KO;
                  frame_cnt_d = KO_HOLD - 8'd1;
                  if ((health1_d == 10'd0) && (health2_d == 10'd0)) winner_d = 2'd3;
                  else if (health2_d == 10'd0)                      winner_d = 2'd1;
                  else                                              winner_d = 2'd2;
               end
            end

            S_KO: begin
               if (frame_cnt_q == 8'd0) state_d = S_IDLE;
               else                     frame_cnt_d = frame_cnt_q - 8'd1;
            end

            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         frame_cnt_q <= 8'd0;
         health1_q   <= MAX_HEALTH;
         health2_q   <= MAX_HEALTH;
         cd1_q       <= 6'd0;
         cd2_q       <= 6'd0;
         hit_prev1_q <= 1'b0;
         hit_prev2_q <= 1'b0;
         pulse1_q    <= 1'b0;
         pulse2_q    <= 1'b0;
         winner_q    <= 2'd0;
`ifdef HIT_COMBO_EN
         combo1_q    <= 6'd0;
         combo2_q    <= 6'd0;
`endif
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         health1_q   <= health1_d;
         health2_q   <= health2_d;
         cd1_q       <= cd1_d;
         cd2_q       <= cd2_d;
         hit_prev1_q <= hit_prev1_d;
         hit_prev2_q <= hit_prev2_d;
         pulse1_q    <= pulse1_d;
         pulse2_q    <= pulse2_d;
         winner_q    <= winner_d;
`ifdef HIT_COMBO_EN
         combo1_q    <= combo1_d;
         combo2_q    <= combo2_d;
`endif
      end
   end

   assign health1     = health1_q;
   assign health2     = health2_q;
   assign dmg_pulse1  = pulse1_q;
   assign dmg_pulse2  = pulse2_q;
   assign fight_en    = (state_q == S_FIGHT);
   assign round_state = state_q;
   assign winner      = winner_q;

endmodule

// File: tb/tb_hit_damage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hit_damage_ctrl
//
// Bench for hit_damage_ctrl in its default build (combo feature off).
//   dut   - default parameters, driven by a vector table plus hand sequences
//           (draw KO, async reset in the middle of a fight)
//   dut_s - MAX_HEALTH=25, so the last hit has to saturate at zero
// Expected output words are pushed to a queue before each frame tick is
// driven, and popped and compared once the tick edge has passed.
// -----------------------------------------------------------------------------
module tb_hit_damage_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0;
   logic       start = 1'b0, hit1 = 1'b0, hit2 = 1'b0;
   logic       s_start = 1'b0, s_hit1 = 1'b0;

   logic [9:0] health1, health2, s_health1, s_health2;
   logic       dmg_pulse1, dmg_pulse2, fight_en;
   logic       s_dmg_pulse1, s_dmg_pulse2, s_fight_en;
   logic [1:0] round_state, winner, s_round_state, s_winner;

   int total = 0;
   int bad   = 0;
   int eh1, eh2;

   logic [26:0] exp_q[$];
   logic [26:0] exp_s_q[$];

   always #5 clk = ~clk;

   hit_damage_ctrl dut (
      .Clk(clk), .Reset(rst), .frame_tick(frame_tick), .start(start),
      .hit1(hit1), .hit2(hit2),
      .health1(health1), .health2(health2),
      .dmg_pulse1(dmg_pulse1), .dmg_pulse2(dmg_pulse2),
      .fight_en(fight_en), .round_state(round_state), .winner(winner)
   );

   hit_damage_ctrl #(.MAX_HEALTH(10'd25)) dut_s (
      .Clk(clk), .Reset(rst), .frame_tick(frame_tick), .start(s_start),
      .hit1(s_hit1), .hit2(1'b0),
      .health1(s_health1), .health2(s_health2),
      .dmg_pulse1(s_dmg_pulse1), .dmg_pulse2(s_dmg_pulse2),
      .fight_en(s_fight_en), .round_state(s_round_state), .winner(s_winner)
   );

   typedef struct {
      int         n;
      logic       st;
      logic       h1;
      logic       h2;
      int         e_h1;
      int         e_h2;
      logic       e_p1;
      logic       e_p2;
      logic       e_fe;
      logic [1:0] e_rs;
      logic [1:0] e_win;
   } vec_t;

   vec_t tbl[18];

   function automatic logic [26:0] ev(int h1, int h2, logic p1, logic p2, logic fe,
                                      logic [1:0] rs, logic [1:0] win);
      return {10'(h1), 10'(h2), p1, p2, fe, rs, win};
   endfunction

   function automatic string fmt(logic [26:0] v);
      return $sformatf("h1=%0d h2=%0d p1=%0b p2=%0b fe=%0b rs=%0d win=%0d",
                       v[26:17], v[16:7], v[6], v[5], v[4], v[3:2], v[1:0]);
   endfunction

   // One frame tick: inputs change on a falling edge, frame_tick is high for
   // the rising edge after it, and outputs are sampled on the next falling edge.
   task automatic tick(input logic st, input logic h1, input logic h2);
      @(negedge clk);
      start = st; hit1 = h1; hit2 = h2; frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic check_main(input string name);
      logic [26:0] e, a;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s: expected queue empty", name);
      end else begin
         e = exp_q.pop_front();
         a = {health1, health2, dmg_pulse1, dmg_pulse2, fight_en, round_state, winner};
         if (a !== e) begin
            bad++;
            $display("FAIL %s: got %s want %s", name, fmt(a), fmt(e));
         end
      end
   endtask

   task automatic check_sat(input string name);
      logic [26:0] e, a;
      total++;
      if (exp_s_q.size() == 0) begin
         bad++;
         $display("FAIL %s: expected queue empty", name);
      end else begin
         e = exp_s_q.pop_front();
         a = {s_health1, s_health2, s_dmg_pulse1, s_dmg_pulse2, s_fight_en, s_round_state, s_winner};
         if (a !== e) begin
            bad++;
            $display("FAIL %s: got %s want %s", name, fmt(a), fmt(e));
         end
      end
   endtask

   // Push the expected word for dut, drive one tick, then compare.
   task automatic step(input logic st, input logic h1, input logic h2,
                       input logic [26:0] e, input string name);
      exp_q.push_back(e);
      tick(st, h1, h2);
      check_main(name);
   endtask

   // One scoring edge from the chosen attacker(s) in FIGHT, followed by 30
   // quiet ticks so the next edge lands after the cooldown has expired. The
   // extra clock after the scoring tick (frame_tick low) must clear the pulses.
   task automatic score_round(input logic a1, input logic a2, input string name);
      if (a2) eh1 -= 10;
      if (a1) eh2 -= 10;
      step(1'b0, a1, a2, ev(eh1, eh2, a2, a1, 1'b1, 2'd2, 2'd0), name);
      @(negedge clk);
      total++;
      if (dmg_pulse1 !== 1'b0 || dmg_pulse2 !== 1'b0) begin
         bad++;
         $display("FAIL %s_pulse_clear: got p1=%0b p2=%0b want 0 0", name, dmg_pulse1, dmg_pulse2);
      end
      for (int i = 0; i < 30; i++)
         step(1'b0, 1'b0, 1'b0, ev(eh1, eh2, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0), {name, "_cool"});
   endtask

   task automatic step_s(input logic [26:0] e, input string name);
      exp_s_q.push_back(e);
      tick(1'b0, 1'b0, 1'b0);
      check_sat(name);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Columns: n, start, hit1, hit2 | health1, health2, p1, p2, fight_en, state, winner
      tbl[0]  = '{3,  1'b0, 1'b0, 1'b0, 100, 100, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
      tbl[1]  = '{1,  1'b1, 1'b0, 1'b0, 100, 100, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0};
      tbl[2]  = '{1,  1'b0, 1'b1, 1'b0, 100, 100, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0};
      tbl[3]  = '{57, 1'b0, 1'b0, 1'b0, 100, 100, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0};
      tbl[4]  = '{1,  1'b0, 1'b0, 1'b0, 100, 100, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0};
      tbl[5]  = '{1,  1'b0, 1'b0, 1'b0, 100, 100, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0};
      tbl[6]  = '{1,  1'b0, 1'b1, 1'b0, 100, 90,  1'b0, 1'b1, 1'b1, 2'd2, 2'd0};
      tbl[7]  = '{49, 1'b0, 1'b1, 1'b0, 100, 90,  1'b0, 1'b0, 1'b1, 2'd2, 2'd0};
      tbl[8]  = '{1,  1'b0, 1'b0, 1'b0, 100, 90,  1'b0, 1'b0, 1'b1, 2'd2, 2'd0};
      tbl[9]  = '{1,  1'b0, 1'b1, 1'b0, 100, 80,  1'b0, 1'b1, 1'b1, 2'd2, 2'd0};
      tbl[10] = '{1,  1'b0, 1'b0, 1'b0, 100, 80,  1'b0, 1'b0, 1'b1, 2'd2, 2'd0};
      tbl[11] = '{18, 1'b0, 1'b0, 1'b0, 100, 80,  1'b0, 1'b0, 1'b1, 2'd2, 2'd0};
      tbl[12] = '{1,  1'b0, 1'b1, 1'b0, 100, 80,  1'b0, 1'b0, 1'b1, 2'd2, 2'd0};
      tbl[13] = '{1,  1'b0, 1'b0, 1'b0, 100, 80,  1'b0, 1'b0, 1'b1, 2'd2, 2'd0};
      tbl[14] = '{9,  1'b0, 1'b0, 1'b0, 100, 80,  1'b0, 1'b0, 1'b1, 2'd2, 2'd0};
      tbl[15] = '{1,  1'b0, 1'b1, 1'b0, 100, 70,  1'b0, 1'b1, 1'b1, 2'd2, 2'd0};
      tbl[16] = '{1,  1'b0, 1'b0, 1'b1, 90,  70,  1'b1, 1'b0, 1'b1, 2'd2, 2'd0};
      tbl[17] = '{5,  1'b1, 1'b0, 1'b1, 90,  70,  1'b0, 1'b0, 1'b1, 2'd2, 2'd0};

      // Reset state.
      repeat (3) @(negedge clk);
      exp_q.push_back(ev(100, 100, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
      check_main("reset_state");
      rst = 1'b0;

      // Table: idle, countdown with an ignored hit, FIGHT entry on the 60th
      // tick, held hit scoring once, cooldown rejection, hit2, start ignored.
      for (int r = 0; r < 18; r++)
         for (int k = 0; k < tbl[r].n; k++) begin
            exp_q.push_back(ev(tbl[r].e_h1, tbl[r].e_h2, tbl[r].e_p1, tbl[r].e_p2,
                               tbl[r].e_fe, tbl[r].e_rs, tbl[r].e_win));
            tick(tbl[r].st, tbl[r].h1, tbl[r].h2);
            check_main($sformatf("row%0d_t%0d", r, k));
         end

      // Draw: bring both players to 10, then land both punches on one tick.
      eh1 = 90; eh2 = 70;
      for (int i = 0; i < 31; i++)
         step(1'b0, 1'b0, 1'b0, ev(eh1, eh2, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0), "draw_settle");
      for (int i = 0; i < 2; i++) score_round(1'b0, 1'b1, "draw_p2_hit");
      for (int i = 0; i < 6; i++) score_round(1'b1, 1'b1, "draw_both_hit");
      step(1'b0, 1'b1, 1'b1, ev(0, 0, 1'b1, 1'b1, 1'b0, 2'd3, 2'd3), "draw_ko");
      for (int i = 0; i < 119; i++)
         step(1'b0, 1'b0, 1'b0, ev(0, 0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd3), "ko_hold");
      step(1'b0, 1'b0, 1'b0, ev(0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3), "ko_to_idle");
      step(1'b1, 1'b0, 1'b0, ev(100, 100, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0), "restart");

      // Async reset in the middle of a fight, with health1 at 40.
      for (int i = 0; i < 59; i++)
         step(1'b0, 1'b0, 1'b0, ev(100, 100, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0), "cd2");
      step(1'b0, 1'b0, 1'b0, ev(100, 100, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0), "fight2");
      eh1 = 100; eh2 = 100;
      for (int i = 0; i < 6; i++) score_round(1'b0, 1'b1, "to40");
      @(negedge clk);
      rst = 1'b1;
      #1;
      exp_q.push_back(ev(100, 100, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
      check_main("async_reset");
      @(negedge clk);
      exp_q.push_back(ev(100, 100, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
      check_main("reset_next_clk");
      rst = 1'b0;

      // Saturation on dut_s: 25 -> 15 -> 5 -> 0, P1 wins; winner survives KO hold.
      s_start = 1'b1;
      step_s(ev(25, 25, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0), "s_start");
      s_start = 1'b0;
      for (int i = 0; i < 59; i++) step_s(ev(25, 25, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0), "s_cd");
      step_s(ev(25, 25, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0), "s_fight");
      eh2 = 25;
      for (int h = 0; h < 2; h++) begin
         eh2 -= 10;
         s_hit1 = 1'b1;
         step_s(ev(25, eh2, 1'b0, 1'b1, 1'b1, 2'd2, 2'd0), "s_hit");
         s_hit1 = 1'b0;
         for (int i = 0; i < 30; i++) step_s(ev(25, eh2, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0), "s_cool");
      end
      s_hit1 = 1'b1;
      step_s(ev(25, 0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd1), "s_sat_ko");
      s_hit1 = 1'b0;
      for (int i = 0; i < 119; i++) step_s(ev(25, 0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd1), "s_ko_hold");
      step_s(ev(25, 0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1), "s_idle_winner");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
